ks_sum_stage: RTL and testbench

//  Final (post-prefix) stage of the pipelined Kogge-Stone adder/subtractor.

---
 rtl/ks_sum_stage.sv | 153 +++++++++++++++
 tb/tb_ks_sum_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ks_sum_stage.sv
// ---------------------------------------------------------------------------
// ks_sum_stage
//   Final stage of the pipelined Kogge-Stone adder/subtractor. It takes the
//   carry vector from the last prefix stage and the saved bit propagates. From
//   these it forms the sum and the flags (carry, overflow, zero, negative). It
//   then registers the result behind a valid/ready interface, using a 2-entry
//   skid buffer (output register + skid register).
//
// Handshake: a beat moves on a rising edge when its valid and ready are both
//   high. Upstream must hold i_valid and its data stable while o_ready is low.
//   o_* stay stable while o_valid & !i_ready.
//
// Ports
//   i_clk, i_rst        clock (rising edge), asynchronous active-high reset
//   i_valid / o_ready   upstream handshake (o_ready is registered)
//   i_c0                carry-in (1 = subtract)
//   i_gk                group generates; bit i = carry out of bit i
//   i_p_save            bit propagates a[i]^b[i]
//   o_valid / i_ready   downstream handshake
//   o_sum, o_cout, o_ovf, o_zero, o_neg   registered result and flags
//   o_count             delivered results since reset (wraps)
// ---------------------------------------------------------------------------
module ks_sum_stage #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic             i_c0,
   input  logic [WIDTH-1:0] i_gk,
   input  logic [WIDTH-1:0] i_p_save,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout,
   output logic             o_ovf,
   output logic             o_zero,
   output logic             o_neg,
   output logic [CNT_W-1:0] o_count
);

   // Occupancy: EMPTY = nothing held, ONE = output reg full,
   // TWO = output reg and skid reg full.
   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_t;

   // Result record layout: {sum, cout, ovf, zero, neg}
   localparam int RW = WIDTH + 4;

   state_t           state, state_nxt;
   logic             ready_q;
   logic [RW-1:0]    out_q, skid_q;
   logic [CNT_W-1:0] count_q;

   logic [WIDTH-1:0] carry, sum_new;
   logic [RW-1:0]    res_new;
   logic             accept, deliver;
   logic             load_out_new, load_out_skid, load_skid;

   // Carry into bit i is the group generate of bit i-1; bit 0 takes the carry-in.
   always_comb begin
      carry   = {i_gk[WIDTH-2:0], i_c0};
      sum_new = i_p_save ^ carry;
      res_new = {sum_new,
                 i_gk[WIDTH-1],
                 i_gk[WIDTH-1] ^ i_gk[WIDTH-2],
                 (sum_new == '0),
                 sum_new[WIDTH-1]};
   end

   assign o_valid = (state != S_EMPTY);
   assign o_ready = ready_q;
   assign accept  = i_valid & ready_q;
   assign deliver = o_valid & i_ready;

   // Next-state logic and register load enables
   always_comb begin
      state_nxt     = state;
      load_out_new  = 1'b0;
      load_out_skid = 1'b0;
      load_skid     = 1'b0;
      case (state)
         S_EMPTY: begin
            if (accept) begin
               load_out_new = 1'b1;
               state_nxt    = S_ONE;
            end
         end
         S_ONE: begin
            if (accept && deliver) begin
               load_out_new = 1'b1;
            end else if (accept) begin
               load_skid = 1'b1;
               state_nxt = S_TWO;
            end else if (deliver) begin
               state_nxt = S_EMPTY;
            end
         end
         S_TWO: begin
            // o_ready is low here, so no new beat can arrive
            if (deliver) begin
               load_out_skid = 1'b1;
               state_nxt     = S_ONE;
            end
         end
         default: state_nxt = S_EMPTY;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state   <= S_EMPTY;
         ready_q <= 1'b1;
      end else begin
         state   <= state_nxt;
         ready_q <= (state_nxt != S_TWO);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         out_q  <= '0;
         skid_q <= '0;
      end else begin
         if (load_out_new)
            out_q <= res_new;
         else if (load_out_skid)
            out_q <= skid_q;
         if (load_skid)
            skid_q <= res_new;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         count_q <= '0;
      else if (deliver)
         count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   assign o_sum   = out_q[RW-1:4];
   assign o_cout  = out_q[3];
   assign o_ovf   = out_q[2];
   assign o_zero  = out_q[1];
   assign o_neg   = out_q[0];
   assign o_count = count_q;

endmodule

// File: tb/tb_ks_sum_stage.sv
// ---------------------------------------------------------------------------
// tb_ks_sum_stage
//   Bench for ks_sum_stage. A second instance with a 4-bit counter shares the
//   same inputs, so that the counter wrap can be exercised.
// ---------------------------------------------------------------------------
module tb_ks_sum_stage;
   localparam int W  = 32;
   localparam int RW = W + 4;

   // ---------------- clock / reset ----------------
   logic i_clk = 1'b0;
   logic i_rst = 1'b1;
   always #5 i_clk = ~i_clk;

   logic          i_valid = 1'b0, i_ready = 1'b0, i_c0 = 1'b0;
   logic [W-1:0]  i_gk = '0, i_p_save = '0;
   logic          o_ready, o_valid, o_cout, o_ovf, o_zero, o_neg;
   logic [W-1:0]  o_sum;
   logic [15:0]   o_count;
   logic          o_ready_w, o_valid_w, o_cout_w, o_ovf_w, o_zero_w, o_neg_w;
   logic [W-1:0]  o_sum_w;
   logic [3:0]    o_count_w;

   ks_sum_stage #(.WIDTH(W), .CNT_W(16)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
      .i_c0(i_c0), .i_gk(i_gk), .i_p_save(i_p_save), .o_valid(o_valid),
      .i_ready(i_ready), .o_sum(o_sum), .o_cout(o_cout), .o_ovf(o_ovf),
      .o_zero(o_zero), .o_neg(o_neg), .o_count(o_count));

   ks_sum_stage #(.WIDTH(W), .CNT_W(4)) dut_w (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready_w),
      .i_c0(i_c0), .i_gk(i_gk), .i_p_save(i_p_save), .o_valid(o_valid_w),
      .i_ready(i_ready), .o_sum(o_sum_w), .o_cout(o_cout_w), .o_ovf(o_ovf_w),
      .o_zero(o_zero_w), .o_neg(o_neg_w), .o_count(o_count_w));

   // ---------------- scoreboard ----------------
   int checks = 0;
   int failures = 0;
   logic [RW-1:0] exp_q[$];      // beats held inside the stage, oldest first
   logic [RW-1:0] cur_exp = '0;  // expected result of the beat on the inputs
   int cnt_model = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Called at a falling edge with inputs set: checks outputs against the
   // occupancy model, then advances the model across the next rising edge.
   task automatic step();
      logic acc, del;
      acc = i_valid && (exp_q.size() < 2);
      del = (exp_q.size() > 0) && i_ready;
      chk("o_valid", {63'd0, o_valid}, {63'd0, exp_q.size() > 0});
      chk("o_ready", {63'd0, o_ready}, {63'd0, exp_q.size() < 2});
      if (exp_q.size() > 0)
         chk("result", {28'd0, o_sum, o_cout, o_ovf, o_zero, o_neg}, {28'd0, exp_q[0]});
      chk("o_count", {48'd0, o_count}, 64'(cnt_model % 65536));
      chk("o_count_w", {60'd0, o_count_w}, 64'(cnt_model % 16));
      @(posedge i_clk);
      if (del) begin
         void'(exp_q.pop_front());
         cnt_model++;
      end
      if (acc) exp_q.push_back(cur_exp);
      @(negedge i_clk);
   endtask

   // Reference: plain integer addition of a and (possibly inverted) b.
   // The prefix-stage vectors are derived from the true sum.
   task automatic gen_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      logic [W-1:0] be, cin, s;
      logic [W:0]   full;
      logic         ovf;
      be   = sub ? ~b : b;
      full = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, sub};
      s    = full[W-1:0];
      cin  = a ^ be ^ s;  // carry into each bit
      ovf  = (a[W-1] == be[W-1]) && (s[W-1] != a[W-1]);
      i_c0     = sub;
      i_p_save = a ^ be;
      i_gk     = {full[W], cin[W-1:1]};
      cur_exp  = {s, full[W], ovf, (s == '0), s[W-1]};
   endtask

   function automatic logic [W-1:0] rand_op();
      case ($urandom_range(0, 5))
         0: return 32'h0000_0000;
         1: return 32'h7FFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // ---------------- directed vectors ----------------
   typedef struct {
      logic         c0;
      logic [W-1:0] p;
      logic [W-1:0] gk;
      logic [W-1:0] sum;
      logic         cout, ovf, zero, neg;
   } vec_t;

   vec_t vecs[5];

   initial begin
      vecs[0] = '{1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0}; // -1+1
      vecs[1] = '{1'b0, 32'h7FFF_FFFE, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1}; // overflow
      vecs[2] = '{1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFD, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b0}; // 5-3
      vecs[3] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0}; // 0+0
      vecs[4] = '{1'b0, 32'h0000_0003, 32'h0000_0000, 32'h0000_0003, 1'b0, 1'b0, 1'b0, 1'b0}; // 1+2

      // Reset state
      repeat (3) @(negedge i_clk);
      chk("rst_o_valid", {63'd0, o_valid}, 64'd0);
      chk("rst_o_ready", {63'd0, o_ready}, 64'd1);
      chk("rst_result", {28'd0, o_sum, o_cout, o_ovf, o_zero, o_neg}, 64'd0);
      chk("rst_o_count", {48'd0, o_count}, 64'd0);
      i_rst = 1'b0;

      // Streaming: 100 beats, valid and ready held high
      i_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         gen_beat(rand_op(), rand_op(), 1'($urandom_range(0, 1)));
         i_valid = 1'b1;
         step();
      end
      i_valid = 1'b0;
      step();
      chk("stream_count", {48'd0, o_count}, 64'd100);

      // Table-driven vectors, one beat at a time
      for (int i = 0; i < 5; i++) begin
         i_c0 = vecs[i].c0; i_p_save = vecs[i].p; i_gk = vecs[i].gk;
         cur_exp = {vecs[i].sum, vecs[i].cout, vecs[i].ovf, vecs[i].zero, vecs[i].neg};
         i_valid = 1'b1; i_ready = 1'b1;
         step();
         i_valid = 1'b0;
         chk("vec_sum", {32'd0, o_sum}, {32'd0, vecs[i].sum});
         chk("vec_flags", {60'd0, o_cout, o_ovf, o_zero, o_neg},
             {60'd0, vecs[i].cout, vecs[i].ovf, vecs[i].zero, vecs[i].neg});
         step();
      end

      // Backpressure: A, B, C back to back with downstream stalled
      i_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         gen_beat(rand_op(), rand_op(), 1'($urandom_range(0, 1)));
         i_valid = 1'b1;
         step();
      end
      chk("bp_o_ready_low", {63'd0, o_ready}, 64'd0);
      step();  // C still held, stage full
      i_ready = 1'b1;
      step();  // A out, C still waiting
      step();  // B out, C accepted
      i_valid = 1'b0;
      step();  // C out
      step();
      chk("bp_drained", {63'd0, o_valid}, 64'd0);

      // Random valid/ready traffic; hold a beat while it is not accepted
      for (int i = 0; i < 300; i++) begin
         if (!(i_valid && exp_q.size() == 2)) begin
            gen_beat(rand_op(), rand_op(), 1'($urandom_range(0, 1)));
            i_valid = 1'($urandom_range(0, 3) != 0);
         end
         i_ready = 1'($urandom_range(0, 2) != 0);
         step();
      end
      i_valid = 1'b0; i_ready = 1'b1;
      repeat (3) step();

      // Reset mid-operation from the full state
      i_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         gen_beat(rand_op(), rand_op(), 1'b0);
         i_valid = 1'b1;
         step();
      end
      i_valid = 1'b0;
      chk("pre_rst_full", {63'd0, o_ready}, 64'd0);
      #2 i_rst = 1'b1;
      #1;
      chk("mid_rst_o_valid", {63'd0, o_valid}, 64'd0);
      chk("mid_rst_o_ready", {63'd0, o_ready}, 64'd1);
      chk("mid_rst_o_count", {48'd0, o_count}, 64'd0);
      exp_q.delete();
      cnt_model = 0;
      @(negedge i_clk);
      i_rst = 1'b0;

      // First beat after release: result one cycle later. Then 17 deliveries
      // in total for the counter wrap.
      i_ready = 1'b1;
      gen_beat(32'h0000_0010, 32'h0000_0020, 1'b0);
      i_valid = 1'b1;
      step();
      chk("post_rst_latency", {31'd0, o_valid, o_sum}, {31'd0, 1'b1, 32'h0000_0030});
      for (int i = 0; i < 16; i++) begin
         gen_beat(rand_op(), rand_op(), 1'($urandom_range(0, 1)));
         step();
      end
      i_valid = 1'b0;
      step();
      chk("wrap_count_w", {60'd0, o_count_w}, 64'd1);
      chk("wrap_count", {48'd0, o_count}, 64'd17);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
